// File: rtl/dr_completion_capture.sv
// rtl/dr_completion_capture.sv - dual-rail token completion detector with single-rail output FIFO
// Classifies each dual-rail codeword, enforces spacer/data alternation, and queues decoded tokens.
module dr_completion_capture #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 4,
  parameter int SP_POL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_0,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             phase,
  output logic             err_illegal,
  output logic             err_overflow,
  input  logic             err_clear,
  output logic [15:0]      tok_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic SP = (SP_POL != 0);

  typedef enum logic {
    WAIT_SPACER = 1'b0,
    WAIT_DATA   = 1'b1
  } state_t;

  state_t state_q;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [15:0]      tok_count_q, tok_count_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_overflow_q, err_overflow_d;

  logic any_illegal, all_spacer, all_data;
  logic capture, pop, push, full, overflow;

  // A pair is a spacer when both rails equal SP, illegal when both rails equal ~SP.
  always_comb begin
    any_illegal = 1'b0;
    all_spacer  = 1'b1;
    all_data    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_1[i] == SP && in_0[i] == SP) begin
        all_data = 1'b0;
      end else if (in_1[i] == ~SP && in_0[i] == ~SP) begin
        any_illegal = 1'b1;
        all_data    = 1'b0;
        all_spacer  = 1'b0;
      end else begin
        all_spacer = 1'b0;
      end
    end
  end

  assign capture   = (state_q == WAIT_DATA) && !any_illegal && all_data;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count_q == FULL_CNT);
  // A full FIFO still accepts a token when the head leaves in the same cycle.
  assign push      = capture && (!full || pop);
  assign overflow  = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_SPACER;
    end else if (any_illegal) begin
      state_q <= WAIT_SPACER;
    end else begin
      case (state_q)
        WAIT_SPACER: if (all_spacer) state_q <= WAIT_DATA;
        WAIT_DATA:   if (all_data)   state_q <= WAIT_SPACER;
        default:     state_q <= WAIT_SPACER;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    tok_count_d    = tok_count_q;
    err_illegal_d  = err_clear ? 1'b0 : err_illegal_q;
    err_overflow_d = err_clear ? 1'b0 : err_overflow_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      tok_count_d = tok_count_q + 16'd1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (any_illegal) begin
      err_illegal_d = 1'b1;
    end
    if (overflow) begin
      err_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      tok_count_q    <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      tok_count_q    <= tok_count_d;
      err_illegal_q  <= err_illegal_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // Storage needs no reset; the empty-gated read below hides stale entries.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= in_1;
    end
  end

  assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign phase        = (state_q == WAIT_DATA);
  assign err_illegal  = err_illegal_q;
  assign err_overflow = err_overflow_q;
  assign tok_count    = tok_count_q;

endmodule
